// File: rtl/hwag_pkg.sv
// Shared angle-domain types and constants for the crank angle generator family.
package hwag_pkg;

    localparam int unsigned ANGLE_W         = 16;
    localparam int unsigned TICKS_PER_TOOTH = 64;

    typedef logic [ANGLE_W-1:0] angle_t;

    localparam angle_t ANGLE_MAX = 16'd3839;

    // Circular window: on between rst_a (exclusive) and set (inclusive), counting down.
    typedef struct packed {
        angle_t set;
        angle_t rst_a;
    } win_t;

    // Level-based window membership; set == rst_a is an empty window.
    function automatic logic in_window(input win_t w, input angle_t a);
        logic hit;
        hit = 1'b0;
        if (w.set > w.rst_a) begin
            hit = (a > w.rst_a) && (a <= w.set);
        end else if (w.set < w.rst_a) begin
            hit = (a <= w.set) || (a > w.rst_a);
        end
        return hit;
    endfunction

endpackage

// File: rtl/coil_channel.sv
// One coil output: double-buffered window, registered compare, dwell guard.
module coil_channel
    import hwag_pkg::*;
#(
    parameter int unsigned DWELL_W = 24
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_set,
    input  logic               wr_rst,
    input  angle_t             wr_data,
    input  logic               commit,
    input  logic               angle_valid,
    input  angle_t             angle_d,
    input  logic               valid_d,
    input  logic [DWELL_W-1:0] dwell_max,
    output logic               coil
);

    win_t               shadow;
    win_t               active;
    logic               in_win;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               tripped;
    logic [DWELL_W-1:0] cnt_nxt_c;
    logic               trip_hit_c;

    // Shadow takes writes; active copies the pre-write shadow on a commit edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (wr_set) begin
                shadow.set <= wr_data;
            end
            if (wr_rst) begin
                shadow.rst_a <= wr_data;
            end
        end
    end

    // Stage 2: registered window compare, flushed while unsynchronised.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_win <= 1'b0;
        end else begin
            in_win <= valid_d & in_window(active, angle_d);
        end
    end

    // Next dwell count and trip decision, so the coil drops on the cycle the limit is reached.
    always_comb begin
        cnt_nxt_c  = dwell_cnt;
        trip_hit_c = 1'b0;
        if (coil && (dwell_cnt != '1)) begin
            cnt_nxt_c = dwell_cnt + DWELL_W'(1);
        end
        if (coil && (dwell_max != '0) && (cnt_nxt_c >= dwell_max)) begin
            trip_hit_c = 1'b1;
        end
    end

    // Dwell counter and trip latch, cleared when the window closes or sync is lost.
    always_ff @(posedge clk) begin
        if (!rst || !valid_d || !in_win) begin
            dwell_cnt <= '0;
            tripped   <= 1'b0;
        end else begin
            dwell_cnt <= cnt_nxt_c;
            tripped   <= tripped | trip_hit_c;
        end
    end

    // Stage 3: coil drive, forced low immediately when sync drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            coil <= 1'b0;
        end else begin
            coil <= in_win & ~(tripped | trip_hit_c) & valid_d & angle_valid;
        end
    end

endmodule

// File: rtl/coil_scheduler.sv
// Angle-domain coil scheduler: write decode, wrap detection, commit control.
module coil_scheduler
    import hwag_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL_W  = 24
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            angle_valid,
    input  logic [ANGLE_W-1:0]              angle,
    input  logic                            wr_en,
    input  logic [$clog2(2*CHANNELS)-1:0]   wr_addr,
    input  logic [ANGLE_W-1:0]              wr_data,
    input  logic                            commit_req,
    input  logic [DWELL_W-1:0]              dwell_max,
    output logic [CHANNELS-1:0]             coil,
    output logic                            commit_pending,
    output logic                            wr_err
);

    localparam int unsigned ADDR_W = $clog2(2*CHANNELS);
    localparam int unsigned CH_W   = ADDR_W - 1;

    angle_t              angle_d;
    logic                valid_d;
    logic                wrap_c;
    logic                wr_ok_c;
    logic [CHANNELS-1:0] wr_set_c;
    logic [CHANNELS-1:0] wr_rst_c;

    // Stage 1: sample the generator angle and sync flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            angle_d <= '0;
            valid_d <= 1'b0;
        end else begin
            angle_d <= angle;
            valid_d <= angle_valid;
        end
    end

    // Wrap is the first synchronised sample of the top angle; writes above it are rejected.
    always_comb begin
        wrap_c  = angle_valid && (angle == ANGLE_MAX) && (angle_d != ANGLE_MAX);
        wr_ok_c = wr_en && (wr_data <= ANGLE_MAX);
    end

    // Commit status and write-error pulse; a request coinciding with a wrap stays armed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_pending <= 1'b0;
            wr_err         <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok_c;
            if (wrap_c) begin
                commit_pending <= commit_req;
            end else if (commit_req) begin
                commit_pending <= 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        // Address decode: upper bits pick the channel, bit 0 picks set/reset.
        always_comb begin
            wr_set_c[ch] = wr_ok_c && (wr_addr[ADDR_W-1:1] == CH_W'(ch)) && !wr_addr[0];
            wr_rst_c[ch] = wr_ok_c && (wr_addr[ADDR_W-1:1] == CH_W'(ch)) &&  wr_addr[0];
        end

        coil_channel #(
            .DWELL_W (DWELL_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_set      (wr_set_c[ch]),
            .wr_rst      (wr_rst_c[ch]),
            .wr_data     (wr_data),
            .commit      (wrap_c),
            .angle_valid (angle_valid),
            .angle_d     (angle_d),
            .valid_d     (valid_d),
            .dwell_max   (dwell_max),
            .coil        (coil[ch])
        );
    end

endmodule

// File: tb/tb_coil_scheduler.sv
// Directed bench for coil_scheduler.
module tb_coil_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        angle_valid;
    logic [15:0] angle;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit_req;
    logic [23:0] dwell_max;
    logic [3:0]  coil;
    logic        commit_pending;
    logic        wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    int         angle_log[$];
    logic [3:0] coil_log[$];

    always #5 clk = ~clk;

    coil_scheduler #(.CHANNELS(4), .DWELL_W(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .angle_valid    (angle_valid),
        .angle          (angle),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .dwell_max      (dwell_max),
        .coil           (coil),
        .commit_pending (commit_pending),
        .wr_err         (wr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int hold);
        for (int i = 0; i < hold; i++) begin
            angle = 16'(a);
            tick();
            angle_log.push_back(a);
            coil_log.push_back(coil);
        end
    endtask

    task automatic clear_log();
        angle_log.delete();
        coil_log.delete();
    endtask

    task automatic sweep_rev();
        for (int a = 3839; a >= 0; a--) drive(a, 1);
    endtask

    task automatic write_reg(input int ch, input int is_rst, input int data);
        wr_en   = 1'b1;
        wr_addr = 3'(ch * 2 + is_rst);
        wr_data = 16'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic int count_high(input int ch, input int from);
        int n;
        n = 0;
        for (int i = from; i < coil_log.size(); i++) if (coil_log[i][ch]) n++;
        return n;
    endfunction

    function automatic int first_high(input int ch);
        for (int i = 0; i < coil_log.size(); i++) if (coil_log[i][ch]) return i;
        return -1;
    endfunction

    function automatic int last_high(input int ch);
        for (int i = coil_log.size() - 1; i >= 0; i--) if (coil_log[i][ch]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; angle_valid = 1'b1; angle = 16'd0; wr_en = 1'b0; wr_addr = 3'd0;
        wr_data = 16'd0; commit_req = 1'b0; dwell_max = 24'd0;
        tick(); tick();
        n_checks++; if (coil !== 4'b0) begin n_fail++; $display("FAIL reset_coil: got %b expected 0000", coil); end
        n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", commit_pending); end
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_window();
        write_reg(0, 0, 50);
        write_reg(0, 1, 1);
        clear_log();
        sweep_rev();
        drive(0, 3);
        n_checks++; if (coil_log[3790][0] !== 1'b0 || coil_log[3791][0] !== 1'b1) begin
            n_fail++; $display("FAIL win_rise: got %b%b expected 01", coil_log[3790][0], coil_log[3791][0]); end
        n_checks++; if (coil_log[3839][0] !== 1'b1 || coil_log[3840][0] !== 1'b0) begin
            n_fail++; $display("FAIL win_fall: got %b%b expected 10", coil_log[3839][0], coil_log[3840][0]); end
        n_checks++; if (count_high(0, 0) != 49) begin n_fail++; $display("FAIL win_ontime: got %0d expected 49", count_high(0, 0)); end
        n_checks++; if (count_high(1, 0) + count_high(2, 0) + count_high(3, 0) != 0) begin
            n_fail++; $display("FAIL win_others: got %0d expected 0", count_high(1, 0) + count_high(2, 0) + count_high(3, 0)); end
    endtask

    task automatic test_wrap_window();
        int run;
        write_reg(1, 0, 10);
        write_reg(1, 1, 3800);
        clear_log();
        sweep_rev();
        sweep_rev();
        run = 0;
        for (int i = 3831; i <= 3880; i++) if (coil_log[i][1]) run++;
        n_checks++; if (run != 50 || coil_log[3830][1] !== 1'b0 || coil_log[3881][1] !== 1'b0) begin
            n_fail++; $display("FAIL wrapwin_continuous: got run %0d edges %b%b expected 50 00", run, coil_log[3830][1], coil_log[3881][1]); end
        n_checks++; if (count_high(1, 0) != 98) begin n_fail++; $display("FAIL wrapwin_total: got %0d expected 98", count_high(1, 0)); end
        n_checks++; if (count_high(0, 0) != 98) begin n_fail++; $display("FAIL wrapwin_ch0: got %0d expected 98", count_high(0, 0)); end
    endtask

    task automatic test_commit();
        clear_log();
        for (int a = 3839; a >= 0; a--) begin
            if (a == 1000) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd200; end
            if (a == 999) commit_req = 1'b1;
            drive(a, 1);
            wr_en = 1'b0;
            commit_req = 1'b0;
            if (a == 999) begin
                n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_armed: got %b expected 1", commit_pending); end
            end
        end
        n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_held: got %b expected 1", commit_pending); end
        n_checks++; if (count_high(0, 0) != 49 || coil_log[3641][0] !== 1'b0) begin
            n_fail++; $display("FAIL commit_old_win: got %0d at200=%b expected 49 0", count_high(0, 0), coil_log[3641][0]); end
        clear_log();
        drive(3839, 1);
        n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_cleared: got %b expected 0", commit_pending); end
        for (int a = 3838; a >= 0; a--) drive(a, 1);
        drive(0, 3);
        n_checks++; if (coil_log[3640][0] !== 1'b0 || coil_log[3641][0] !== 1'b1) begin
            n_fail++; $display("FAIL commit_new_rise: got %b%b expected 01", coil_log[3640][0], coil_log[3641][0]); end
        n_checks++; if (count_high(0, 0) != 199) begin n_fail++; $display("FAIL commit_new_ontime: got %0d expected 199", count_high(0, 0)); end
    endtask

    task automatic test_dwell();
        dwell_max = 24'd100;
        write_reg(0, 0, 50);
        for (int rev = 0; rev < 2; rev++) begin
            clear_log();
            drive(3839, 1);
            for (int a = 60; a >= 0; a--) drive(a, 4);
            drive(0, 4);
            n_checks++; if (count_high(0, 0) != 100) begin n_fail++; $display("FAIL dwell_ontime_rev%0d: got %0d expected 100", rev, count_high(0, 0)); end
            n_checks++; if (first_high(0) != 43 || last_high(0) != 142) begin
                n_fail++; $display("FAIL dwell_span_rev%0d: got %0d..%0d expected 43..142", rev, first_high(0), last_high(0)); end
        end
        dwell_max = 24'd0;
    endtask

    task automatic test_valid_drop();
        int idx;
        clear_log();
        drive(3839, 1);
        for (int a = 60; a >= 31; a--) drive(a, 1);
        n_checks++; if (coil[0] !== 1'b1) begin n_fail++; $display("FAIL vdrop_before: got %b expected 1", coil[0]); end
        angle_valid = 1'b0;
        drive(30, 1);
        n_checks++; if (coil !== 4'b0) begin n_fail++; $display("FAIL vdrop_next: got %b expected 0000", coil); end
        drive(29, 1);
        drive(28, 1);
        n_checks++; if (coil !== 4'b0 || commit_pending !== 1'b0) begin
            n_fail++; $display("FAIL vdrop_hold: got %b %b expected 0000 0", coil, commit_pending); end
        angle_valid = 1'b1;
        idx = coil_log.size();
        for (int a = 27; a >= 0; a--) drive(a, 1);
        drive(0, 3);
        n_checks++; if (coil_log[idx+1][0] !== 1'b0 || coil_log[idx+2][0] !== 1'b1) begin
            n_fail++; $display("FAIL vdrop_resync: got %b%b expected 01", coil_log[idx+1][0], coil_log[idx+2][0]); end
        n_checks++; if (count_high(0, idx) != 26) begin n_fail++; $display("FAIL vdrop_ontime: got %0d expected 26", count_high(0, idx)); end
    endtask

    task automatic test_bad_write();
        write_reg(0, 0, 4000);
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL badwr_pulse: got %b expected 1", wr_err); end
        tick();
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL badwr_clear: got %b expected 0", wr_err); end
        write_reg(3, 1, 3839);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL badwr_max_ok: got %b expected 0", wr_err); end
        write_reg(3, 1, 3840);
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL badwr_3840: got %b expected 1", wr_err); end
        clear_log();
        sweep_rev();
        drive(0, 3);
        n_checks++; if (count_high(0, 0) != 49) begin n_fail++; $display("FAIL badwr_ch0_kept: got %0d expected 49", count_high(0, 0)); end
        n_checks++; if (count_high(3, 0) != 2) begin n_fail++; $display("FAIL badwr_ch3_zero_only: got %0d expected 2", count_high(3, 0)); end
    endtask

    task automatic test_reset_mid_window();
        int total;
        commit_req = 1'b1;
        clear_log();
        drive(3839, 1);
        commit_req = 1'b0;
        n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_wrap_and_req: got %b expected 1", commit_pending); end
        for (int a = 60; a >= 40; a--) drive(a, 1);
        n_checks++; if (coil[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_window: got %b expected 1", coil[0]); end
        rst = 1'b0;
        drive(39, 1);
        n_checks++; if (coil !== 4'b0 || commit_pending !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_cleared: got %b %b expected 0000 0", coil, commit_pending); end
        rst = 1'b1;
        clear_log();
        sweep_rev();
        drive(0, 3);
        total = count_high(0, 0) + count_high(1, 0) + count_high(2, 0) + count_high(3, 0);
        n_checks++; if (total != 0) begin n_fail++; $display("FAIL rstmid_empty: got %0d expected 0", total); end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_wrap_window();
        test_commit();
        test_dwell();
        test_valid_drop();
        test_bad_write();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coil_scheduler.md
# coil_scheduler

Angle-domain output scheduler placed directly downstream of the crank angle generator. It consumes the generator's running angle count (3840 ticks per revolution, counting down) and its sync-valid flag, and drives CHANNELS coil outputs. Each channel is high inside a programmable circular angle window. Window registers are double-buffered and commit only at revolution wrap, and a per-channel dwell guard bounds on-time in clock cycles.

## Interface
- CHANNELS, 4, number of coil outputs
- ANGLE_W, 16, angle bus width
- DWELL_W, 24, dwell guard counter width
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- angle_valid  in  1  generator synchronised (hwag_start)
- angle  in  ANGLE_W  current angle, 0..3839, decrementing
- wr_en  in  1  register write strobe
- wr_addr  in  $clog2(2*CHANNELS)  {channel, 0=set / 1=reset}
- wr_data  in  ANGLE_W  angle value to write
- commit_req  in  1  request shadow→active copy at next wrap
- dwell_max  in  DWELL_W  max on-time in clk cycles, 0 = guard disabled
- coil  out  CHANNELS  coil drive, registered
- commit_pending  out  1  commit armed, not yet applied
- wr_err  out  1  one-cycle pulse, write rejected

## Operation
- Per channel: shadow and active set/reset registers; reset value 0 for all, which gives an empty window.
- Write: if wr_data > 3839, no register changes and wr_err pulses on the next cycle. Otherwise the shadow register is updated.
- commit_req sets commit_pending. A wrap event copies all shadows to actives and clears commit_pending.
- Wrap event: angle_valid=1 and angle==3839 while the previous sampled angle was not 3839.
- Simultaneous wrap and write: the copy uses the pre-write shadow; the write lands in the shadow.
- Simultaneous wrap and commit_req: the copy happens and commit_pending stays 1.
- Window test, using active values:
  - set > reset: in-window when reset < angle <= set.
  - set < reset (wrap window): in-window when angle <= set or angle > reset.
  - set == reset: never in-window.
- Dwell guard, per channel: counter increments each cycle coil is high.
  - When dwell_max != 0 and the counter reaches dwell_max, the channel latches "tripped" and coil goes low.
  - "tripped" clears, and the counter zeroes, when in-window deasserts.
- angle_valid=0: coil forced 0 on the next cycle; in-window pipeline, dwell counters and trip latches cleared. Active, shadow and pending state are retained.
- Reset (rst=0 at a clk edge): all registers and outputs to 0, including coil, commit_pending and wr_err.

## Timing
- Stage 1: register angle and angle_valid.
- Stage 2: registered window compare.
- Stage 3: coil flop = in_window & ~tripped & angle_valid_d.
- Angle→coil latency: 3 clk.
- Write → shadow visible: 1 clk.
- Commit: actives take new values on the clk after the wrap sample. They first affect coil 2 clk later.
- Dwell trip: coil low 1 clk after the counter reaches dwell_max, so on-time is exactly dwell_max cycles.
- Throughput: a new angle is accepted every clk. Angle jumps (reload on tooth edge) are handled because the window test is level-based, not edge-based.

## Structure
- Shared package hwag_pkg:
  - ANGLE_W=16, ANGLE_MAX=16'd3839, TICKS_PER_TOOTH=64.
  - Typedef angle_t.
  - Typedef win_t {angle_t set; angle_t rst_a;}.
- Sub-module coil_channel, instantiated CHANNELS times. It holds the shadow/active win_t, compare pipeline, dwell counter and trip latch.
- Top level holds the write decode, wrap detector and commit logic.

## Test plan
- Ch0 set=50 reset=1, angle swept 3839→0, one step per clk:
  - coil[0] rises 3 clk after angle=50 and falls 3 clk after angle=1.
  - High for exactly 49 clk; other channels stay 0.
- Ch1 set=10 reset=3800, two revolutions:
  - coil[1] high for angles 10..0 and 3839..3801; the output is continuous across the wrap.
- Commit:
  - Write ch0 set=200 at angle 1000, then pulse commit_req.
  - Old window is still used on the remaining sweep; commit_pending=1.
  - After the wrap, commit_pending=0 and the new window 200..2 is used.
- Dwell: dwell_max=100, ch0 window 50..1, angle stepped every 4 clk:
  - coil[0] high exactly 100 clk, then low until the window exits.
  - Re-asserts normally on the next revolution.
- angle_valid dropped at angle 30 inside the window:
  - coil=0 on the next clk.
  - On resync the window resumes with actives intact.
- Bad write and reset:
  - wr_data=4000 → wr_err pulses 1 clk; readback behaviour is unchanged.
  - rst=0 mid-window → coil=0 and commit_pending=0 at the next edge; all windows empty afterwards.
